uart_transmitter: RTL and testbench

Serial transmit half of the APB UART. Accepts one byte from `APB_interface` (`txStart`/`txData`) and serialises it on `txd` as 1 start bit, 8 data bits LSB first, an optional even-parity bit and 1 stop bit. Bit timing matches `Receiver`: CLKS_PER_BIT clock cycles per bit, so a `Receiver` on the same clock samples the frame correctly. Parity matches `PARITY_CHECK`: parity bit = XOR of the data byte.

---
 rtl/uart_transmitter.sv | 129 ++++++++++++
 tb/tb_uart_transmitter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// uart_transmitter
//   Serial transmit half of the APB UART. Sends one byte per request as
//   1 start bit (0), 8 data bits LSB first, an optional even-parity bit
//   (XOR of the byte) and 1 stop bit (1). Every bit lasts CLKS_PER_BIT clocks.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset, highest priority
//   tx_enable    block enable; low aborts any frame and holds IDLE
//   tx_start     send request, only looked at in IDLE
//   tx_data_in   byte to send, captured on acceptance
//   parity_en    insert parity bit, captured on acceptance
//   tx_data_out  serial line, idles high (registered)
//   busy         high for the whole frame, start through stop (registered)
//   done         one-cycle pulse after a frame completes normally (registered)
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_enable,
  input  logic       tx_start,
  input  logic [7:0] tx_data_in,
  input  logic       parity_en,
  output logic       tx_data_out,
  output logic       busy,
  output logic       done
);

  localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    PARITY,
    STOP_BIT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       data_q;
  logic             parity_en_q;

  // Even parity: the inserted bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  // Outputs are set on the same edge that enters each state, so the line
  // level always lines up with the state that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      data_q      <= '0;
      parity_en_q <= 1'b0;
      tx_data_out <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!tx_enable) begin
        // Abort: drop straight back to an idle line, no done for this frame.
        state       <= IDLE;
        cnt         <= '0;
        bit_idx     <= '0;
        tx_data_out <= 1'b1;
        busy        <= 1'b0;
      end else if (state == IDLE) begin
        if (tx_start) begin
          data_q      <= tx_data_in;
          parity_en_q <= parity_en;
          cnt         <= '0;
          bit_idx     <= '0;
          state       <= START_BIT;
          tx_data_out <= 1'b0;
          busy        <= 1'b1;
        end
      end else if (cnt != CNT_LAST) begin
        cnt <= cnt + 1'b1;
      end else begin
        // Bit boundary: advance to the next slot of the frame.
        cnt <= '0;
        case (state)
          START_BIT: begin
            state       <= DATA_BITS;
            bit_idx     <= '0;
            tx_data_out <= data_q[0];
          end
          DATA_BITS: begin
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              if (parity_en_q) begin
                state       <= PARITY;
                tx_data_out <= even_parity(data_q);
              end else begin
                state       <= STOP_BIT;
                tx_data_out <= 1'b1;
              end
            end else begin
              bit_idx     <= bit_idx + 3'd1;
              tx_data_out <= data_q[bit_idx + 3'd1];
            end
          end
          PARITY: begin
            state       <= STOP_BIT;
            tx_data_out <= 1'b1;
          end
          STOP_BIT: begin
            state       <= IDLE;
            tx_data_out <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
          end
          default: begin
            state       <= IDLE;
            tx_data_out <= 1'b1;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
module tb_uart_transmitter;

  localparam int C = 16;

  logic       clk;
  logic       rst;
  logic       tx_enable;
  logic       tx_start;
  logic [7:0] tx_data_in;
  logic       parity_en;
  logic       tx_data_out;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  uart_transmitter #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_enable  (tx_enable),
    .tx_start   (tx_start),
    .tx_data_in (tx_data_in),
    .parity_en  (parity_en),
    .tx_data_out(tx_data_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
      $error("check %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, " line"}, tx_data_out, 1'b1);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " done"}, done, exp_done);
  endtask

  // Reference: the frame is a list of bit levels, each held C cycles.
  // Caller sets tx_start/tx_data_in/parity_en at a negedge; the next posedge
  // is the acceptance edge and each negedge after that is cycle 1, 2, ...
  // Returns at the negedge of the done cycle (or of abort_k when aborting).
  task automatic check_frame(input string name, input logic [7:0] d, input logic p,
                             input bit hold, input int glitch_k, input int abort_k);
    logic bits[$];
    int   len;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (p) bits.push_back(^d);
    bits.push_back(1'b1);
    len = bits.size() * C;
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) tx_start = 1'b0;
      if (k <= len) begin
        chk($sformatf("%s line c%0d", name, k), tx_data_out, bits[(k - 1) / C]);
        chk($sformatf("%s busy c%0d", name, k), busy, 1'b1);
        chk($sformatf("%s done c%0d", name, k), done, 1'b0);
      end else begin
        chk($sformatf("%s done-cycle line c%0d", name, k), tx_data_out, 1'b1);
        chk($sformatf("%s done-cycle busy c%0d", name, k), busy, 1'b0);
        chk($sformatf("%s done-cycle done c%0d", name, k), done, 1'b1);
      end
      if (!hold && k == glitch_k) begin
        tx_start   = 1'b1;
        tx_data_in = ~d;
        parity_en  = ~p;
      end
      if (!hold && glitch_k > 0 && k == glitch_k + 1) tx_start = 1'b0;
      if (k == abort_k) begin
        tx_enable = 1'b0;
        return;
      end
    end
  endtask

  task automatic launch(input logic [7:0] d, input logic p);
    tx_start   = 1'b1;
    tx_data_in = d;
    parity_en  = p;
  endtask

  initial begin
    logic [7:0] rd;
    logic       rp;
    int         gap;

    rst        = 1'b1;
    tx_enable  = 1'b1;
    tx_start   = 1'b0;
    tx_data_in = 8'h00;
    parity_en  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_idle("reset", 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post-reset idle", 1'b0);

    // 0xA5 with parity: parity 0, done in cycle 177
    launch(8'hA5, 1'b1);
    check_frame("a5p", 8'hA5, 1'b1, 1'b0, 0, 0);
    @(negedge clk);
    chk_idle("a5p after", 1'b0);

    // 0x07 with parity: parity bit 1
    launch(8'h07, 1'b1);
    check_frame("07p", 8'h07, 1'b1, 1'b0, 0, 0);
    @(negedge clk);
    chk_idle("07p after", 1'b0);

    // Start request and new data during DATA_BITS are ignored
    launch(8'h96, 1'b0);
    check_frame("glitch", 8'h96, 1'b0, 1'b0, 2 * C + 5, 0);
    @(negedge clk);
    chk_idle("glitch after", 1'b0);

    // Held tx_start: 0x3C without parity (160 cycles), then back-to-back frame
    launch(8'h3C, 1'b0);
    check_frame("3cnp", 8'h3C, 1'b0, 1'b1, 0, 0);
    rd = 8'($urandom);
    rp = 1'($urandom);
    tx_data_in = rd;
    parity_en  = rp;
    check_frame("b2b", rd, rp, 1'b0, 0, 0);
    @(negedge clk);
    chk_idle("b2b after", 1'b0);

    // Abort during data bit 3, no done afterwards
    launch(8'h5A, 1'b1);
    check_frame("abort", 8'h5A, 1'b1, 1'b0, 0, 4 * C + 8);
    @(negedge clk);
    chk_idle("abort edge", 1'b0);
    tx_enable = 1'b1;
    for (int i = 0; i < 12 * C; i++) begin
      @(negedge clk);
      chk($sformatf("abort quiet done %0d", i), done, 1'b0);
      chk($sformatf("abort quiet line %0d", i), tx_data_out, 1'b1);
    end
    launch(8'hC3, 1'b1);
    check_frame("re-enable", 8'hC3, 1'b1, 1'b0, 0, 0);
    @(negedge clk);

    // Reset held 3 cycles mid-frame, then a normal frame
    launch(8'hFF, 1'b0);
    @(negedge clk);
    tx_start = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle($sformatf("midreset %0d", i), 1'b0);
    end
    rst = 1'b0;
    launch(8'h81, 1'b1);
    check_frame("post-rst", 8'h81, 1'b1, 1'b0, 0, 0);
    @(negedge clk);

    // Random frames with random idle gaps
    for (int n = 0; n < 6; n++) begin
      gap = int'($urandom_range(0, 5));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk_idle($sformatf("rnd%0d gap", n), 1'b0);
      end
      rd = 8'($urandom);
      rp = 1'($urandom);
      launch(rd, rp);
      check_frame($sformatf("rnd%0d", n), rd, rp, 1'b0, 0, 0);
      @(negedge clk);
      chk_idle($sformatf("rnd%0d after", n), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
